// File: rtl/hplvds_rx_link.sv
// hplvds_rx_link
//   Receive-side link controller for an HPLVDS pad. Sequences the pad
//   (termination, receiver and electrical-idle detector) through power-up and
//   settle. It then qualifies exit from electrical idle and aligns the serial
//   stream to SYNC_WORD. Once locked, it frames 8-bit words into a one-entry
//   valid/ready holding register.
//
//   Optional build macro: HPLVDS_RX_ERRCNT_EN
//     defined   -> ERR_CNT_O counts LOCK-to-IDLE events, saturating at 8'hFF
//     undefined -> ERR_CNT_O is tied to 0 and no counter is built
//
// Ports
//   CLK_I           clock
//   RST_I           synchronous active-high reset
//   EN_I            link enable; low forces OFF from any state
//   POL_I           receive polarity, passed straight to the pad
//   DI_I            serial data from the pad (polarity already applied)
//   EI_DETECT_I     electrical-idle flag from the pad
//   RX_EN_O         pad receiver enable
//   RTERM_EN_O      pad termination enable
//   EI_DETECT_EN_O  pad electrical-idle detector enable
//   RX_POL_O        pad receiver polarity
//   DATA_O[7:0]     received word
//   VALID_O         DATA_O holds a word
//   READY_I         consumer accepts the word
//   LOCKED_O        link is aligned (state LOCK)
//   OVF_O           sticky overflow: a word was dropped while one was pending
//   ERR_CNT_O[7:0]  lock-loss count
//
// state  | meaning
// -------+----------------------------------------------------------------
// OFF    | pad fully disabled, waiting for EN_I
// SETTLE | pad enabled, waiting SETTLE_CYC cycles for termination/receiver
// IDLE   | waiting for EI_DETECT_I low for EI_QUAL_CYC consecutive cycles
// ALIGN  | hunting for SYNC_WORD in the serial stream
// LOCK   | framing 8-bit words; EI_QUAL_CYC cycles of idle fall back to IDLE

module hplvds_rx_link #(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned EI_QUAL_CYC = 4,
  parameter logic [7:0]  SYNC_WORD   = 8'hBC
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       EN_I,
  input  logic       POL_I,
  input  logic       DI_I,
  input  logic       EI_DETECT_I,
  output logic       RX_EN_O,
  output logic       RTERM_EN_O,
  output logic       EI_DETECT_EN_O,
  output logic       RX_POL_O,
  output logic [7:0] DATA_O,
  output logic       VALID_O,
  input  logic       READY_I,
  output logic       LOCKED_O,
  output logic       OVF_O,
  output logic [7:0] ERR_CNT_O
);

  localparam int unsigned SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned QCW = (EI_QUAL_CYC > 1) ? $clog2(EI_QUAL_CYC) : 1;
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYC - 1);
  localparam logic [QCW-1:0] QUAL_LOAD   = QCW'(EI_QUAL_CYC - 1);

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    SETTLE = 3'd1,
    IDLE   = 3'd2,
    ALIGN  = 3'd3,
    LOCK   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [QCW-1:0]   qual_cnt_q, qual_cnt_d;
  // Only the last 7 bits are kept: the 8-bit window is {hist_q, DI_I},
  // so a word or sync match is seen on the edge that samples its last bit.
  logic [6:0]       hist_q, hist_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       window;
  logic             word_done;

  assign window = {hist_q, DI_I};

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q      <= OFF;
      settle_cnt_q <= '0;
      qual_cnt_q   <= '0;
      hist_q       <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      qual_cnt_q   <= qual_cnt_d;
      hist_q       <= hist_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    qual_cnt_d   = qual_cnt_q;
    hist_d       = hist_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    valid_d      = valid_q;
    ovf_d        = ovf_q;
    word_done    = 1'b0;

    if (!EN_I) begin
      state_d      = OFF;
      settle_cnt_d = SETTLE_LOAD;
      qual_cnt_d   = QUAL_LOAD;
      hist_d       = '0;
      bit_cnt_d    = '0;
      valid_d      = 1'b0;
      ovf_d        = 1'b0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d      = SETTLE;
          settle_cnt_d = SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_d    = IDLE;
            qual_cnt_d = QUAL_LOAD;
          end else begin
            settle_cnt_d = settle_cnt_q - SCW'(1);
          end
        end
        IDLE: begin
          hist_d    = '0;
          bit_cnt_d = '0;
          if (EI_DETECT_I) begin
            qual_cnt_d = QUAL_LOAD;
          end else if (qual_cnt_q == '0) begin
            state_d    = ALIGN;
            qual_cnt_d = QUAL_LOAD;
          end else begin
            qual_cnt_d = qual_cnt_q - QCW'(1);
          end
        end
        ALIGN, LOCK: begin
          hist_d = window[6:0];
          if (state_q == ALIGN) begin
            if (window == SYNC_WORD) begin
              state_d   = LOCK;
              bit_cnt_d = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            word_done = (bit_cnt_q == 3'd7) && (window != SYNC_WORD);
          end
          // Idle qualification runs across ALIGN->LOCK without restarting;
          // an idle exit overrides a same-cycle sync match.
          if (!EI_DETECT_I) begin
            qual_cnt_d = QUAL_LOAD;
          end else if (qual_cnt_q == '0) begin
            state_d    = IDLE;
            qual_cnt_d = QUAL_LOAD;
          end else begin
            qual_cnt_d = qual_cnt_q - QCW'(1);
          end
        end
        default: state_d = OFF;
      endcase

      if (word_done) begin
        if (!valid_q || READY_I) begin
          data_d  = window;
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (valid_q && READY_I) begin
        valid_d = 1'b0;
      end
    end
  end

  assign RX_EN_O        = (state_q != OFF);
  assign RTERM_EN_O     = (state_q != OFF);
  assign EI_DETECT_EN_O = (state_q != OFF);
  assign RX_POL_O       = POL_I;
  assign LOCKED_O       = (state_q == LOCK);
  assign DATA_O         = data_q;
  assign VALID_O        = valid_q;
  assign OVF_O          = ovf_q;

`ifdef HPLVDS_RX_ERRCNT_EN
  logic       lock_loss;
  logic [7:0] err_cnt_q;

  assign lock_loss = (state_q == LOCK) && (state_d == IDLE);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      err_cnt_q <= 8'h00;
    end else if (lock_loss && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign ERR_CNT_O = err_cnt_q;
`else
  assign ERR_CNT_O = 8'h00;
`endif

endmodule
